// File: rtl/multiplier_control.sv
// Sequencer for the signed shift-add multiplier datapath: synchronizes the
// push buttons and issues one-hot clear/load/add/sub/shift commands.
module multiplier_control #(
  parameter int NBITS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Run,
  input  logic                     ClearA_LoadB,
  input  logic                     M,
  output logic                     Clr_Ld,
  output logic                     ClrXA,
  output logic                     Add,
  output logic                     Sub,
  output logic                     Shift,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(NBITS)-1:0] Step
);

  localparam int STEP_W = $clog2(NBITS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ADD, SHIFT, HOLD} state_t;

  state_t                  state, state_next;
  logic [STEP_W-1:0]       step, step_next;
  logic                    done_flag, done_flag_next;
  logic [SYNC_STAGES-1:0]  run_sync, clr_sync;
  logic                    run_s, clr_s;

  // Synchronizers idle at 1 so a reset never looks like a button press.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_sync <= '1;
      clr_sync <= '1;
    end else begin
      run_sync <= {run_sync[SYNC_STAGES-2:0], Run};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], ClearA_LoadB};
    end
  end

  assign run_s = run_sync[SYNC_STAGES-1];
  assign clr_s = clr_sync[SYNC_STAGES-1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      step      <= '0;
      done_flag <= 1'b0;
    end else begin
      state     <= state_next;
      step      <= step_next;
      done_flag <= done_flag_next;
    end
  end

  // done_flag marks the first HOLD cycle so Done pulses once per multiply.
  always_comb begin
    state_next     = state;
    step_next      = step;
    done_flag_next = 1'b0;
    Clr_Ld         = 1'b0;
    ClrXA          = 1'b0;
    Add            = 1'b0;
    Sub            = 1'b0;
    Shift          = 1'b0;
    Busy           = 1'b0;
    Done           = 1'b0;

    unique case (state)
      IDLE: begin
        if (!run_s) begin
          state_next = CLEAR;
        end else begin
          Clr_Ld = !clr_s;
        end
      end
      CLEAR: begin
        ClrXA      = 1'b1;
        Busy       = 1'b1;
        step_next  = '0;
        state_next = ADD;
      end
      ADD: begin
        Busy       = 1'b1;
        Add        = M && (step != LAST_STEP);
        Sub        = M && (step == LAST_STEP);
        state_next = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (step == LAST_STEP) begin
          step_next      = '0;
          done_flag_next = 1'b1;
          state_next     = HOLD;
        end else begin
          step_next  = step + STEP_W'(1);
          state_next = ADD;
        end
      end
      HOLD: begin
        Done = done_flag;
        if (run_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Step = step;

endmodule

// File: tb/tb_multiplier_control.sv
// Randomized scoreboard bench: a timeline model of the controller predicts
// every cycle's outputs, a monitor compares them against the DUT.
module tb_multiplier_control;

  localparam int N = 8;
  localparam int S = 2;

  typedef logic [9:0] vec_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Run = 1'b1;
  logic       ClearA_LoadB = 1'b1;
  logic       M;
  logic       Clr_Ld, ClrXA, Add, Sub, Shift, Busy, Done;
  logic [2:0] Step;

  logic [7:0] sw = 8'h00;
  logic [7:0] cur_sw = 8'h00;
  logic [7:0] b_reg = 8'h00;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_dones = 0;
  int   dut_dones = 0;

  vec_t exp_q[$];
  bit   run_h[$];
  bit   clr_h[$];
  bit   rst_h[$];

  int         m_mode = 0;
  int         m_t0 = 0;
  logic [7:0] m_b = 8'h00;

  multiplier_control #(.NBITS(N), .SYNC_STAGES(S)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .ClrXA(ClrXA), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done), .Step(Step)
  );

  always #5 Clk = ~Clk;

  // Stand-in for the B register of the datapath: only its LSB feeds M.
  assign M = b_reg[0];
  always @(posedge Clk) begin
    if (Clr_Ld) b_reg <= sw;
    else if (Shift) b_reg <= b_reg >> 1;
  end

  function automatic bit syncOf(input bit is_run, input int c);
    if (c - S < 0) return 1'b1;
    for (int j = c - S; j <= c; j++)
      if (!rst_h[j]) return 1'b1;
    return is_run ? run_h[c - S] : clr_h[c - S];
  endfunction

  // Offset t from the first CLEAR cycle fixes every command of a multiply.
  task automatic applyStimulus(input bit run, input bit clr, input bit rst);
    bit rs, cs, clr_ld, clrxa, add, sub, shft, busy, done;
    int t, step;
    @(posedge Clk);
    #1;
    Run = run; ClearA_LoadB = clr; Reset = rst; sw = cur_sw;
    run_h.push_back(run); clr_h.push_back(clr); rst_h.push_back(rst);
    {clr_ld, clrxa, add, sub, shft, busy, done} = '0;
    step = 0;
    if (!rst) begin
      m_mode = 0;
    end else begin
      rs = syncOf(1'b1, cyc);
      cs = syncOf(1'b0, cyc);
      if (m_mode == 0) begin
        if (!rs) begin
          m_mode = 1;
          m_t0 = cyc + 1;
        end else if (!cs) begin
          clr_ld = 1'b1;
          m_b = cur_sw;
        end
      end else begin
        t = cyc - m_t0;
        if (t == 0) begin
          clrxa = 1'b1; busy = 1'b1;
        end else if (t <= 2 * N && t % 2 == 1) begin
          busy = 1'b1;
          step = (t - 1) / 2;
          if (m_b[0]) begin
            if (step < N - 1) add = 1'b1;
            else sub = 1'b1;
          end
        end else if (t <= 2 * N) begin
          busy = 1'b1; shft = 1'b1;
          step = (t - 2) / 2;
          m_b = m_b >> 1;
        end else begin
          done = (t == 2 * N + 1);
          if (done) exp_dones++;
          if (rs) m_mode = 0;
        end
      end
    end
    exp_q.push_back({clr_ld, clrxa, add, sub, shft, busy, done, 3'(step)});
    cyc++;
  endtask

  always @(negedge Clk) begin
    vec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {Clr_Ld, ClrXA, Add, Sub, Shift, Busy, Done, Step};
      total++;
      if (a !== e) begin
        bad++;
        if (bad <= 30)
          $display("[TB] FAIL outputs t=%0t got=%b want=%b (Clr_Ld,ClrXA,Add,Sub,Shift,Busy,Done,Step)",
                   $time, a, e);
      end
      total++;
      if ($countones({Clr_Ld, ClrXA, Add, Sub, Shift}) > 1) begin
        bad++;
        $display("[TB] FAIL onehot t=%0t got=%b want=at most one command", $time,
                 {Clr_Ld, ClrXA, Add, Sub, Shift});
      end
      if (Done === 1'b1) dut_dones++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1);
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int i;
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    idle(4);

    cur_sw = 8'h5A;
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b1);
    idle(6);

    cur_sw = 8'h07;
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle(25);

    cur_sw = 8'hFF;
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    idle(25);

    cur_sw = 8'hA5;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 40; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    idle(5);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    idle(25);

    cur_sw = 8'h3C;
    applyStimulus(1'b1, 1'b0, 1'b1);
    i = 0;
    while (i < 60 && !(m_mode == 1 && cyc - m_t0 == 8)) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      i++;
    end
    checkOutput("reach_shift_step3", (i < 60) ? 1 : 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) applyStimulus(1'b0, 1'b1, 1'b1);
    idle(5);

    for (int k = 0; k < 500; k++) begin
      if (k % 60 == 0) cur_sw = 8'($urandom);
      applyStimulus($urandom_range(0, 99) >= 12, $urandom_range(0, 99) >= 20,
                    $urandom_range(0, 249) != 0);
    end
    idle(25);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    #1;
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("done_count", dut_dones, exp_dones);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
